imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 8, giving the word-address width, with 2**ADDR_W >= DEPTH_WORDS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  incoming program byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  32  instruction-memory write word.
REQ-011 SHALL have port core_rst  output  1  holds the processor core in reset while high.
REQ-012 SHALL have port load_done  output  1  program fully loaded (sticky).
REQ-013 SHALL have port load_err  output  1  header word count illegal (sticky).
REQ-014 SHALL have port words_loaded  output  16  number of words written so far.

Function
REQ-015 SHALL count a byte as accepted only on a rising edge where rx_valid and rx_ready are both 1; rx_data with rx_ready=0 SHALL be ignored; gaps in rx_valid SHALL be allowed without timeout.
REQ-016 SHALL implement the states HDR_LO, HDR_HI, DATA, LAST, DONE and ERR.
REQ-017 SHALL drive rx_ready=1 in HDR_LO, HDR_HI and DATA, and rx_ready=0 in LAST, DONE and ERR.
REQ-018 HDR_LO: the accepted byte SHALL become count[7:0], then go to HDR_HI.
REQ-019 HDR_HI: the accepted byte SHALL become count[15:8]; the next state is then decided on the full 16-bit count.
  - count==0: go to DONE.
  - count>DEPTH_WORDS: go to ERR.
  - otherwise: go to DATA.
REQ-020 DATA SHALL assemble each word little-endian: byte k (0..3) of the word goes to bits [8k+7:8k].
REQ-021 On acceptance of byte 3, imem_we SHALL be 1 for exactly the following cycle.
  - imem_addr SHALL equal the current word index (first word is 0).
  - imem_wdata SHALL equal the assembled word.
  - word index and words_loaded SHALL increment by 1 at the end of that cycle.
REQ-022 In DATA, rx_ready SHALL stay 1 during a non-final write cycle, so the next word's byte 0 can be accepted in the same cycle as the write.
REQ-023 On acceptance of byte 3 of word count-1, the FSM SHALL go to LAST, where imem_we=1 for the final word; the next edge SHALL go to DONE.
REQ-024 imem_we SHALL be 0 in every cycle not defined by REQ-021 and REQ-023; imem_addr and imem_wdata are don't-care when imem_we=0.
REQ-025 core_rst SHALL be 1 in every state except DONE, and 0 in DONE.
REQ-026 load_done SHALL be 1 in DONE only.
REQ-027 DONE and ERR SHALL be absorbing; only rst exits them.
REQ-028 ERR SHALL drive load_err=1, core_rst=1 and imem_we=0.
REQ-029 words_loaded SHALL never exceed count, and imem_addr SHALL never reach DEPTH_WORDS.

Reset
REQ-030 When rst=1 at a rising edge, the FSM SHALL enter HDR_LO and clear all of the following:
  - count
  - byte index
  - word index
  - partial word
  - words_loaded
REQ-031 Output values while in reset and in the first cycle after reset:
  - rx_ready=1
  - imem_we=0
  - core_rst=1
  - load_done=0
  - load_err=0
  - words_loaded=0
REQ-032 A reset during any state, including mid-word, SHALL discard the partial word; words already written to memory are not erased.
REQ-033 rst SHALL take priority over a simultaneous byte handshake; that byte is dropped.

Verification
REQ-034 Header 0x02,0x00 then bytes 13,05,00,00,93,05,10,00 at full rate SHALL produce the following:
  - first write: addr 0, data 0x00000513;
  - second write: addr 1, data 0x00100593, in LAST;
  - then load_done=1, core_rst=0, words_loaded=2.
REQ-035 Header 0x00,0x00 SHALL give DONE one cycle after byte 2 with no imem_we pulse and words_loaded=0.
REQ-036 Header 0x01,0x01 (count 257, DEPTH 256) SHALL give load_err=1, rx_ready=0 and core_rst=1; further rx_valid SHALL produce no writes.
REQ-037 Header 0x01,0x00, bytes AA,BB with rst pulsed, then a fresh header 0x01,0x00 and bytes 11,22,33,44 SHALL produce a single write: addr 0, data 0x44332211.
REQ-038 Bytes with random rx_valid gaps, plus rx_valid held high during LAST and DONE, SHALL keep the word contents intact and produce no extra writes.

Source files
------------

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
// Groups the byte stream feeding the loader and the instruction-memory write
// port it drives.
//   rx_data/rx_valid/rx_ready : program byte stream (valid/ready handshake)
//   imem_we/imem_addr/imem_wdata : word write port into instruction memory
// Modports:
//   master : byte source / memory side (drives rx_data, rx_valid)
//   slave  : the loader itself (drives rx_ready and the write port)
// ----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Boot loader that receives a program over a byte stream and writes it into
// instruction memory while holding the core in reset.
// Stream format: 16-bit little-endian word count, then count 32-bit words,
// each sent little-endian (byte 0 first).
// Ports:
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   bus          : imem_loader_if.slave (byte stream in, memory write port out)
//   core_rst     : high except once loading has completed
//   load_done    : sticky, program fully loaded
//   load_err     : sticky, header word count larger than the memory
//   words_loaded : number of words written so far
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          core_rst,
    output logic          load_done,
    output logic          load_err,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        LAST,
        DONE,
        ERR
    } state_t;

    // 17 bits so a 16-bit header count can be compared without truncation.
    localparam logic [16:0] DEPTH_17 = 17'(DEPTH_WORDS);

    state_t            state_q;
    state_t            state_d;
    logic              ready_int;
    logic              accept;
    logic [15:0]       hdr_count;
    logic              last_word;

    logic [15:0]       count_q;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       partial;
    logic [31:0]       wdata_q;
    logic              wr_pending;

    assign accept    = bus.rx_valid && ready_int;
    // Full count as it will be once the high header byte is taken.
    assign hdr_count = {bus.rx_data, count_q[7:0]};
    // words_loaded is up to date whenever byte 3 arrives: the previous
    // word's write cycle always finishes before the next word's byte 3.
    assign last_word = (words_loaded == count_q - 16'd1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake readiness
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        ready_int = 1'b0;
        unique case (state_q)
            HDR_LO: begin
                ready_int = 1'b1;
                if (accept) state_d = HDR_HI;
            end
            HDR_HI: begin
                ready_int = 1'b1;
                if (accept) begin
                    if (hdr_count == 16'd0)               state_d = DONE;
                    else if ({1'b0, hdr_count} > DEPTH_17) state_d = ERR;
                    else                                   state_d = DATA;
                end
            end
            DATA: begin
                ready_int = 1'b1;
                if (accept && byte_idx == 2'd3 && last_word) state_d = LAST;
            end
            LAST:    state_d = DONE;
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = HDR_LO;
        endcase
    end

    // ------------------------------------------------------------------
    // Header, word assembly and write bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            partial      <= '0;
            wdata_q      <= '0;
            wr_pending   <= 1'b0;
            words_loaded <= '0;
        end else begin
            wr_pending <= 1'b0;

            // Close out the write cycle. The final write keeps word_idx on
            // the last address so it never reaches the memory depth.
            if (wr_pending) begin
                words_loaded <= words_loaded + 16'd1;
                if (state_q != LAST) word_idx <= word_idx + ADDR_W'(1);
            end

            if (accept) begin
                unique case (state_q)
                    HDR_LO: count_q[7:0]  <= bus.rx_data;
                    HDR_HI: count_q[15:8] <= bus.rx_data;
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: partial[7:0]   <= bus.rx_data;
                            2'd1: partial[15:8]  <= bus.rx_data;
                            2'd2: partial[23:16] <= bus.rx_data;
                            2'd3: begin
                                wdata_q    <= {bus.rx_data, partial};
                                wr_pending <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; rst forces the reset-state values even before the first edge
    // ------------------------------------------------------------------
    assign bus.rx_ready   = rst || ready_int;
    assign bus.imem_we    = wr_pending && !rst;
    assign bus.imem_addr  = word_idx;
    assign bus.imem_wdata = wdata_q;
    assign core_rst       = rst || (state_q != DONE);
    assign load_done      = !rst && (state_q == DONE);
    assign load_err       = !rst && (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: reset values, a two-word program, empty and
// oversize headers, reset mid-word, and gapped input with valid held high
// after the last byte.
// ----------------------------------------------------------------------------
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .DEPTH_WORDS(256),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .core_rst    (core_rst),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Write log captured mid-cycle, away from the rising edge.
    int                wr_count = 0;
    logic [ADDR_W-1:0] wr_addr [16];
    logic [31:0]       wr_data [16];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wr_count < 16) begin
                wr_addr[wr_count] <= bus.imem_addr;
                wr_data[wr_count] <= bus.imem_wdata;
            end
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 20 && bus.rx_ready !== 1'b1; i++) tick();
        check("rx_ready_before_byte", 32'(bus.rx_ready), 32'd1);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Reset with a byte offered at the same edge; that byte must be dropped.
    task automatic do_reset();
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hCC;
        tick();
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] f_bytes [12];
    int         base;

    initial begin
        f_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE,
                    8'h67, 8'h45, 8'h23, 8'h01,
                    8'h0D, 8'hF0, 8'hFE, 8'hCA};

        // ---- Reset values, with a byte offered during reset ----
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        tick();
        check("rst_rx_ready",     32'(bus.rx_ready), 32'd1);
        check("rst_imem_we",      32'(bus.imem_we),  32'd0);
        check("rst_core_rst",     32'(core_rst),     32'd1);
        check("rst_load_done",    32'(load_done),    32'd0);
        check("rst_load_err",     32'(load_err),     32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        check("post_rst_rx_ready",  32'(bus.rx_ready), 32'd1);
        check("post_rst_imem_we",   32'(bus.imem_we),  32'd0);
        check("post_rst_core_rst",  32'(core_rst),     32'd1);
        check("post_rst_load_done", 32'(load_done),    32'd0);

        // ---- Two-word program at full rate ----
        send(8'h02, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
        check("w0_we",        32'(bus.imem_we),   32'd1);
        check("w0_addr",      32'(bus.imem_addr), 32'd0);
        check("w0_data",      bus.imem_wdata,     32'h0000_0513);
        check("w0_rx_ready",  32'(bus.rx_ready),  32'd1);
        check("w0_words",     32'(words_loaded),  32'd0);
        send(8'h93, 0);
        check("w0_words_after", 32'(words_loaded), 32'd1);
        check("w1_gap_we",      32'(bus.imem_we),  32'd0);
        send(8'h05, 0); send(8'h10, 0); send(8'h00, 0);
        check("last_we",        32'(bus.imem_we),   32'd1);
        check("last_addr",      32'(bus.imem_addr), 32'd1);
        check("last_data",      bus.imem_wdata,     32'h0010_0593);
        check("last_rx_ready",  32'(bus.rx_ready),  32'd0);
        check("last_load_done", 32'(load_done),     32'd0);
        check("last_core_rst",  32'(core_rst),      32'd1);
        tick();
        check("done_load_done", 32'(load_done),    32'd1);
        check("done_core_rst",  32'(core_rst),     32'd0);
        check("done_words",     32'(words_loaded), 32'd2);
        check("done_we",        32'(bus.imem_we),  32'd0);
        check("prog_wr_count",  32'(wr_count),     32'd2);

        // ---- Empty program ----
        do_reset();
        base = wr_count;
        send(8'h00, 0); send(8'h00, 0);
        check("empty_load_done", 32'(load_done),    32'd1);
        check("empty_core_rst",  32'(core_rst),     32'd0);
        check("empty_words",     32'(words_loaded), 32'd0);
        check("empty_load_err",  32'(load_err),     32'd0);
        tick();
        check("empty_no_write",  32'(wr_count),     32'(base));

        // ---- Oversize header (257 words) ----
        do_reset();
        base = wr_count;
        send(8'h01, 0); send(8'h01, 0);
        check("err_load_err",  32'(load_err),     32'd1);
        check("err_rx_ready",  32'(bus.rx_ready), 32'd0);
        check("err_core_rst",  32'(core_rst),     32'd1);
        check("err_load_done", 32'(load_done),    32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (8) tick();
        bus.rx_valid = 1'b0;
        check("err_no_write",  32'(wr_count),     32'(base));
        check("err_sticky",    32'(load_err),     32'd1);
        check("err_words",     32'(words_loaded), 32'd0);

        // ---- Reset mid-word discards the partial word ----
        do_reset();
        base = wr_count;
        send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
        do_reset();
        send(8'h01, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check("mid_rst_we",   32'(bus.imem_we),   32'd1);
        check("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        check("mid_rst_data", bus.imem_wdata,     32'h4433_2211);
        tick();
        check("mid_rst_done",     32'(load_done),    32'd1);
        check("mid_rst_words",    32'(words_loaded), 32'd1);
        check("mid_rst_wr_count", 32'(wr_count),     32'(base + 1));

        // ---- Three words with random gaps, valid held after the last byte ----
        do_reset();
        base = wr_count;
        send(8'h03, 2); send(8'h00, 1);
        for (int i = 0; i < 12; i++) send(f_bytes[i], int'($urandom_range(0, 3)));
        check("gap_last_we",   32'(bus.imem_we),   32'd1);
        check("gap_last_addr", 32'(bus.imem_addr), 32'd2);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        repeat (6) tick();
        bus.rx_valid = 1'b0;
        check("gap_wr_count",  32'(wr_count),       32'(base + 3));
        check("gap_addr0",     32'(wr_addr[base]),     32'd0);
        check("gap_data0",     wr_data[base],          32'hDEAD_BEEF);
        check("gap_addr1",     32'(wr_addr[base + 1]), 32'd1);
        check("gap_data1",     wr_data[base + 1],      32'h0123_4567);
        check("gap_addr2",     32'(wr_addr[base + 2]), 32'd2);
        check("gap_data2",     wr_data[base + 2],      32'hCAFE_F00D);
        check("gap_words",     32'(words_loaded),   32'd3);
        check("gap_load_done", 32'(load_done),      32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
